dram_refresh_sched: RTL and testbench
=====================================

# dram_refresh_sched

Refresh scheduler and access arbiter for the DRAM controller. It owns the shared command handshake (`cmd_req`/`cmd_ack`, `cmd`) between the access FSM and the DRAM array. It also times periodic refreshes. Refreshes are postponed while accesses are pending, up to a credit limit; at the limit, a refresh is forced after the current access drains. It sits between `dram_fsm` and the DRAM command port and drives the controller-level `refresh_flag`.

## Interface
- `REFRESH_INTERVAL`, 780 — cycles between refresh obligations (≥2).
- `MAX_POSTPONE`, 8 — maximum owed refreshes before a refresh is forced (≥1).
- `REFRESH_CYCLES`, 16 — tRFC: cycles `cmd_req` is held after `cmd_ack` rises (≥1).
- `NUM_OF_ROWS`, 128 — rows refreshed round-robin.
- `clk`  in  1  — single clock, rising edge.
- `rst_b`  in  1  — reset, asynchronous, active-low.
- `acc_req`  in  1  — access FSM has a pending access.
- `acc_busy`  in  1  — access FSM is mid-transaction and cannot be interrupted.
- `acc_grant`  out  1  — access FSM may use the command port.
- `cmd_req`  out  1  — refresh command request, 4-phase handshake.
- `cmd_ack`  in  1  — DRAM acknowledge.
- `cmd`  out  2  — `2'b11` (REFRESH) while `cmd_req` is high, else `2'b00`.
- `ref_row`  out  $clog2(NUM_OF_ROWS)  — row targeted by the current or next refresh.
- `refresh_flag`  out  1  — one-cycle pulse on entry to REF_REQ.
- `pending_cnt`  out  $clog2(MAX_POSTPONE+1)  — refreshes owed.
- `ref_overrun`  out  1  — sticky; an interval expired while `pending_cnt == MAX_POSTPONE`.

## Operation
- Interval counter: loads `REFRESH_INTERVAL-1` and counts down. At 0 it emits an internal `tick` and reloads.
- `tick` increments `pending_cnt`, saturating at `MAX_POSTPONE`. A `tick` at saturation sets `ref_overrun`, which clears only on reset.
- A refresh completes (`done`) on the REF_DONE→IDLE transition; `done` decrements `pending_cnt`.
- `tick` and `done` in the same cycle leave `pending_cnt` unchanged, and `ref_overrun` is not set.
- `urgent` = (`pending_cnt == MAX_POSTPONE`).
- IDLE: if `urgent`, or `pending_cnt>0` with `!acc_req`, go to REF_REQ. Else if `acc_req`, go to GRANT.
- GRANT: `acc_grant=1`.
  - If `urgent`, go to DRAIN.
  - Else if `!acc_req && !acc_busy`, go to IDLE.
- DRAIN: `acc_grant=0`. When `!acc_busy`, go to REF_REQ.
- REF_REQ: `cmd_req=1`. When `cmd_ack`, load the tRFC counter with `REFRESH_CYCLES-1` and go to REF_WAIT.
- REF_WAIT: `cmd_req=1`; count down. At 0, go to REF_DONE.
- REF_DONE: `cmd_req=0`. When `!cmd_ack`:
  - `ref_row` increments, wrapping `NUM_OF_ROWS-1`→0.
  - `pending_cnt` decrements.
  - Go to IDLE.
- `acc_grant` and `cmd_req` are never high in the same cycle.
- `cmd_ack` is ignored in IDLE, GRANT and DRAIN.
- `acc_req` is ignored during REF_*; the access waits for the refresh to finish.

## Timing
- Reset values: all outputs 0. State is IDLE, interval counter at `REFRESH_INTERVAL-1`, `ref_row=0`.
- All outputs are registered, decoded from state and counter registers. No input reaches an output combinationally.
- With `REFRESH_INTERVAL=N`, the first `tick` occurs on the N-th rising edge after `rst_b` deasserts. `pending_cnt` reads 1 on the following cycle.
- `refresh_flag` and `cmd_req` rise in the same cycle.
- `cmd_req` stays high for exactly `REFRESH_CYCLES` cycles after the first cycle in which `cmd_ack` is sampled high.
- IDLE→GRANT takes 1 cycle, so `acc_grant` rises one cycle after `acc_req` is sampled.
- Urgent preemption: `acc_grant` drops 1 cycle after `urgent` is sampled. `cmd_req` rises 1 cycle after `acc_busy` is sampled low in DRAIN.
- Asynchronous reset mid-refresh drops `cmd_req` and `acc_grant` immediately. Owed refreshes and `ref_overrun` are discarded.
- The interval counter runs in every state, including during refresh.

## Test plan
Bench parameters: `REFRESH_INTERVAL=20`, `MAX_POSTPONE=2`, `REFRESH_CYCLES=4`, `NUM_OF_ROWS=4`. The DRAM model acknowledges 8 ns after each `cmd_req` edge.
- Idle refresh, `acc_req=0`:
  - `refresh_flag` pulses 1 cycle after the first tick.
  - `cmd_req` is high for the ack latency plus 4 cycles.
  - `ref_row` goes 0→1; `pending_cnt` goes 1→0.
- Postponement, `acc_req=1` and `acc_busy=1` held continuously:
  - `acc_grant` stays 1 through 1 tick; `pending_cnt=1`.
  - At the 2nd tick, `pending_cnt=2` (urgent) and `acc_grant` drops.
  - `cmd_req` rises only after `acc_busy` is released.
- Overrun: `acc_busy=1` held for 3 intervals.
  - `ref_overrun=1` after the 3rd tick; `pending_cnt` stays 2.
  - After release, two refreshes run back-to-back.
- Row wrap: 5 consecutive idle refreshes.
  - `ref_row` sequence 1,2,3,0,1.
- Simultaneous events: align a tick with the REF_DONE exit.
  - `pending_cnt` is unchanged; no overrun.
- Reset mid-REF_WAIT:
  - `cmd_req`, `acc_grant`, `pending_cnt` and `ref_row` are all 0 asynchronously.
  - The first tick after release occurs 20 cycles later.
- All scenarios: assert `acc_grant && cmd_req` never occurs.

Source files
------------

// File: rtl/dram_refresh_sched.sv
// Refresh scheduler and command-port arbiter: times periodic refreshes, lets
// pending accesses postpone them up to a credit limit, then forces one.
module dram_refresh_sched #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_POSTPONE     = 8,
  parameter int REFRESH_CYCLES   = 16,
  parameter int NUM_OF_ROWS      = 128
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic                               acc_req,
  input  logic                               acc_busy,
  output logic                               acc_grant,
  output logic                               cmd_req,
  input  logic                               cmd_ack,
  output logic [1:0]                         cmd,
  output logic [$clog2(NUM_OF_ROWS)-1:0]     ref_row,
  output logic                               refresh_flag,
  output logic [$clog2(MAX_POSTPONE+1)-1:0]  pending_cnt,
  output logic                               ref_overrun
);

  localparam int INT_W  = $clog2(REFRESH_INTERVAL);
  localparam int RFC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int PEND_W = $clog2(MAX_POSTPONE + 1);

  localparam logic [INT_W-1:0]  INT_LOAD  = INT_W'(REFRESH_INTERVAL - 1);
  localparam logic [RFC_W-1:0]  RFC_LOAD  = RFC_W'(REFRESH_CYCLES - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_OF_ROWS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_POSTPONE);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    DRAIN,
    REF_REQ,
    REF_WAIT,
    REF_DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [INT_W-1:0]  interval_cnt;
  logic [RFC_W-1:0]  rfc_cnt;
  logic              tick;
  logic              done;
  logic              urgent;
  logic              enter_req;

  assign tick      = (interval_cnt == '0);
  assign done      = (state == REF_DONE) && !cmd_ack;
  assign urgent    = (pending_cnt == PEND_MAX);
  assign enter_req = (next_state == REF_REQ) && (state != REF_REQ);

  // Free-running interval timer; keeps counting through refreshes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      interval_cnt <= INT_LOAD;
    end else if (tick) begin
      interval_cnt <= INT_LOAD;
    end else begin
      interval_cnt <= interval_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rfc_cnt <= '0;
    end else if ((state == REF_REQ) && cmd_ack) begin
      rfc_cnt <= RFC_LOAD;
    end else if ((state == REF_WAIT) && (rfc_cnt != '0)) begin
      rfc_cnt <= rfc_cnt - 1'b1;
    end
  end

  // A tick and a completion in the same cycle cancel, so no overrun there.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pending_cnt <= '0;
      ref_overrun <= 1'b0;
    end else if (tick && !done) begin
      if (urgent) begin
        ref_overrun <= 1'b1;
      end else begin
        pending_cnt <= pending_cnt + 1'b1;
      end
    end else if (done && !tick && (pending_cnt != '0)) begin
      pending_cnt <= pending_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ref_row <= '0;
    end else if (done) begin
      ref_row <= (ref_row == ROW_LAST) ? '0 : ref_row + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      refresh_flag <= 1'b0;
    end else begin
      state        <= next_state;
      refresh_flag <= enter_req;
    end
  end

  // Outputs decode only the state register, so grant and request stay exclusive.
  always_comb begin
    next_state = state;
    acc_grant  = 1'b0;
    cmd_req    = 1'b0;
    unique case (state)
      IDLE: begin
        if (urgent || ((pending_cnt != '0) && !acc_req)) begin
          next_state = REF_REQ;
        end else if (acc_req) begin
          next_state = GRANT;
        end
      end
      GRANT: begin
        acc_grant = 1'b1;
        if (urgent) begin
          next_state = DRAIN;
        end else if (!acc_req && !acc_busy) begin
          next_state = IDLE;
        end
      end
      DRAIN: begin
        if (!acc_busy) begin
          next_state = REF_REQ;
        end
      end
      REF_REQ: begin
        cmd_req = 1'b1;
        if (cmd_ack) begin
          next_state = REF_WAIT;
        end
      end
      REF_WAIT: begin
        cmd_req = 1'b1;
        if (rfc_cnt == '0) begin
          next_state = REF_DONE;
        end
      end
      REF_DONE: begin
        if (!cmd_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign cmd = cmd_req ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_dram_refresh_sched.sv
// Directed bench for dram_refresh_sched: idle refresh, postponement, overrun,
// row wrap, tick/done collision and asynchronous reset during a refresh.
module tb_dram_refresh_sched;

  localparam int RI = 20;
  localparam int MP = 2;
  localparam int RC = 4;
  localparam int NR = 4;

  logic       clk      = 1'b0;
  logic       rst_b    = 1'b0;
  logic       acc_req  = 1'b0;
  logic       acc_busy = 1'b0;
  logic       cmd_ack  = 1'b0;
  logic       acc_grant;
  logic       cmd_req;
  logic [1:0] cmd;
  logic [1:0] ref_row;
  logic       refresh_flag;
  logic [1:0] pending_cnt;
  logic       ref_overrun;

  int cyc;
  int checks = 0;
  int errors = 0;

  dram_refresh_sched #(
    .REFRESH_INTERVAL(RI),
    .MAX_POSTPONE(MP),
    .REFRESH_CYCLES(RC),
    .NUM_OF_ROWS(NR)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .acc_req(acc_req),
    .acc_busy(acc_busy),
    .acc_grant(acc_grant),
    .cmd_req(cmd_req),
    .cmd_ack(cmd_ack),
    .cmd(cmd),
    .ref_row(ref_row),
    .refresh_flag(refresh_flag),
    .pending_cnt(pending_cnt),
    .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; edge n makes cyc == n.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // DRAM model: acknowledge follows cmd_req 8 ns after each edge.
  always begin
    @(cmd_req);
    #8;
    cmd_ack = cmd_req;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b) checkOutput("grant_cmd_excl", int'(acc_grant & cmd_req), 0);
  end

  task automatic applyStimulus(input logic req, input logic busy);
    acc_req  = req;
    acc_busy = busy;
  endtask

  task automatic stepTo(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst_b = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput({tag, "_grant"},   int'(acc_grant), 0);
    checkOutput({tag, "_cmd_req"}, int'(cmd_req), 0);
    checkOutput({tag, "_cmd"},     int'(cmd), 0);
    checkOutput({tag, "_row"},     int'(ref_row), 0);
    checkOutput({tag, "_flag"},    int'(refresh_flag), 0);
    checkOutput({tag, "_pending"}, int'(pending_cnt), 0);
    checkOutput({tag, "_overrun"}, int'(ref_overrun), 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    // Idle refresh
    doReset("rst0");
    stepTo(19);
    checkOutput("idle_pend19", int'(pending_cnt), 0);
    stepTo(20);
    checkOutput("idle_pend20", int'(pending_cnt), 1);
    checkOutput("idle_req20", int'(cmd_req), 0);
    stepTo(21);
    checkOutput("idle_flag21", int'(refresh_flag), 1);
    checkOutput("idle_req21", int'(cmd_req), 1);
    checkOutput("idle_cmd21", int'(cmd), 3);
    stepTo(22);
    checkOutput("idle_flag22", int'(refresh_flag), 0);
    checkOutput("idle_req22", int'(cmd_req), 1);
    stepTo(25);
    checkOutput("idle_req25", int'(cmd_req), 1);
    stepTo(26);
    checkOutput("idle_req26", int'(cmd_req), 0);
    checkOutput("idle_cmd26", int'(cmd), 0);
    checkOutput("idle_row26", int'(ref_row), 0);
    stepTo(27);
    checkOutput("idle_pend27", int'(pending_cnt), 0);
    checkOutput("idle_row27", int'(ref_row), 1);

    // Postponement and urgent preemption
    doReset("rst1");
    applyStimulus(1'b1, 1'b1);
    stepTo(1);
    checkOutput("post_grant1", int'(acc_grant), 1);
    stepTo(20);
    checkOutput("post_pend20", int'(pending_cnt), 1);
    checkOutput("post_grant20", int'(acc_grant), 1);
    stepTo(39);
    checkOutput("post_grant39", int'(acc_grant), 1);
    stepTo(40);
    checkOutput("post_pend40", int'(pending_cnt), 2);
    checkOutput("post_grant40", int'(acc_grant), 1);
    stepTo(41);
    checkOutput("post_grant41", int'(acc_grant), 0);
    checkOutput("post_req41", int'(cmd_req), 0);
    stepTo(45);
    checkOutput("post_req45", int'(cmd_req), 0);
    applyStimulus(1'b0, 1'b0);
    stepTo(46);
    checkOutput("post_req46", int'(cmd_req), 1);
    checkOutput("post_flag46", int'(refresh_flag), 1);
    stepTo(52);
    checkOutput("post_pend52", int'(pending_cnt), 1);
    checkOutput("post_row52", int'(ref_row), 1);
    stepTo(53);
    checkOutput("post_req53", int'(cmd_req), 1);
    stepTo(59);
    checkOutput("post_pend59", int'(pending_cnt), 0);
    checkOutput("post_row59", int'(ref_row), 2);

    // Overrun
    doReset("rst2");
    applyStimulus(1'b1, 1'b1);
    stepTo(41);
    checkOutput("ovr_grant41", int'(acc_grant), 0);
    stepTo(59);
    checkOutput("ovr_flag59", int'(ref_overrun), 0);
    checkOutput("ovr_pend59", int'(pending_cnt), 2);
    stepTo(60);
    checkOutput("ovr_flag60", int'(ref_overrun), 1);
    checkOutput("ovr_pend60", int'(pending_cnt), 2);
    stepTo(62);
    applyStimulus(1'b0, 1'b0);
    stepTo(63);
    checkOutput("ovr_req63", int'(cmd_req), 1);
    stepTo(69);
    checkOutput("ovr_pend69", int'(pending_cnt), 1);
    checkOutput("ovr_row69", int'(ref_row), 1);
    checkOutput("ovr_req69", int'(cmd_req), 0);
    stepTo(70);
    checkOutput("ovr_req70", int'(cmd_req), 1);
    checkOutput("ovr_rflag70", int'(refresh_flag), 1);
    stepTo(76);
    checkOutput("ovr_pend76", int'(pending_cnt), 0);
    checkOutput("ovr_row76", int'(ref_row), 2);
    checkOutput("ovr_sticky76", int'(ref_overrun), 1);

    // Row wrap over five idle refreshes
    doReset("rst3");
    for (int i = 0; i < 5; i++) begin
      stepTo(20 * i + 27);
      checkOutput($sformatf("wrap_row%0d", i), int'(ref_row), (i + 1) % NR);
      checkOutput($sformatf("wrap_pend%0d", i), int'(pending_cnt), 0);
    end

    // Tick coincident with refresh completion at saturation
    doReset("rst4");
    applyStimulus(1'b1, 1'b1);
    stepTo(41);
    checkOutput("sim_pend41", int'(pending_cnt), 2);
    stepTo(53);
    applyStimulus(1'b0, 1'b0);
    stepTo(54);
    checkOutput("sim_req54", int'(cmd_req), 1);
    stepTo(59);
    checkOutput("sim_req59", int'(cmd_req), 0);
    checkOutput("sim_pend59", int'(pending_cnt), 2);
    stepTo(60);
    checkOutput("sim_pend60", int'(pending_cnt), 2);
    checkOutput("sim_ovr60", int'(ref_overrun), 0);
    checkOutput("sim_row60", int'(ref_row), 1);
    stepTo(61);
    checkOutput("sim_req61", int'(cmd_req), 1);
    checkOutput("sim_flag61", int'(refresh_flag), 1);

    // Asynchronous reset during REF_WAIT
    doReset("rst5");
    stepTo(44);
    checkOutput("mid_req44", int'(cmd_req), 1);
    checkOutput("mid_row44", int'(ref_row), 1);
    checkOutput("mid_pend44", int'(pending_cnt), 1);
    doReset("mid");
    stepTo(19);
    checkOutput("mid_pend19", int'(pending_cnt), 0);
    stepTo(20);
    checkOutput("mid_pend20", int'(pending_cnt), 1);
    stepTo(21);
    checkOutput("mid_req21", int'(cmd_req), 1);
    checkOutput("mid_row21", int'(ref_row), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
